// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with on-time/dead-time sequencing,
// hex decode, leading-zero blanking and a frame-synchronous double-buffered display.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        lzb,
  output logic [3:0]  dis_sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_en;
  } disp_buf_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  disp_buf_t     shadow_q, shadow_d;
  disp_buf_t     pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic [3:0]    dis_sel_q, dis_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          boundary;
  logic [3:0]    nibble;
  logic          lz_blank;

  function automatic logic [6:0] decode_hex(input logic [3:0] h);
    case (h)
      4'h0: decode_hex = 7'b1000000;
      4'h1: decode_hex = 7'b1111001;
      4'h2: decode_hex = 7'b0100100;
      4'h3: decode_hex = 7'b0110000;
      4'h4: decode_hex = 7'b0011001;
      4'h5: decode_hex = 7'b0010010;
      4'h6: decode_hex = 7'b0000010;
      4'h7: decode_hex = 7'b1111000;
      4'h8: decode_hex = 7'b0000000;
      4'h9: decode_hex = 7'b0010000;
      4'hA: decode_hex = 7'b0001000;
      4'hB: decode_hex = 7'b0000011;
      4'hC: decode_hex = 7'b1000110;
      4'hD: decode_hex = 7'b0100001;
      4'hE: decode_hex = 7'b0000110;
      default: decode_hex = 7'b0001110;
    endcase
  endfunction

  // Sequencing and buffer management.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    boundary        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            idx_d    = idx_q + 2'd1;
            boundary = (idx_q == 2'd3);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d    = '0;
          state_d  = SHOW;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d  = IDLE;
      idx_d    = 2'd0;
      cnt_d    = '0;
      boundary = 1'b0;
    end

    // Live data bypasses the pending stage when idle or exactly at the frame swap.
    if (state_q == IDLE) begin
      if (load) shadow_d = '{digits: digits, dp_en: dp_en};
    end else if (boundary) begin
      if (load)                 shadow_d = '{digits: digits, dp_en: dp_en};
      else if (pending_valid_q) shadow_d = pending_q;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = '{digits: digits, dp_en: dp_en};
      pending_valid_d = 1'b1;
    end

    frame_done_d = boundary;
  end

  // Outputs are derived from next-state values so they register on the same edge as the state.
  always_comb begin
    nibble = shadow_d.digits[{idx_d, 2'b00} +: 4];
    lz_blank = 1'b0;
    if (lzb) begin
      case (idx_d)
        2'd3:    lz_blank = (shadow_d.digits[15:12] == 4'h0);
        2'd2:    lz_blank = (shadow_d.digits[15:8]  == 8'h00);
        2'd1:    lz_blank = (shadow_d.digits[15:4]  == 12'h000);
        default: lz_blank = 1'b0;
      endcase
    end

    dis_sel_d = 4'b1111;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    if (state_d == SHOW) begin
      dis_sel_d = ~(4'b0001 << idx_d);
      seg_d     = lz_blank ? 7'h7F : decode_hex(nibble);
      dp_d      = ~shadow_d.dp_en[idx_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= 2'd0;
      cnt_q           <= '0;
      // NOTE: the display buffers are reset too, so a fresh enable never shows stale data.
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      dis_sel_q       <= 4'b1111;
      seg_q           <= 7'h7F;
      dp_q            <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      dis_sel_q       <= dis_sel_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign dis_sel    = dis_sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: one instance with a blank phase, one without.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, load = 1'b0, lzb = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_en = '0;
  logic [3:0]  dis_sel;
  logic [6:0]  seg;
  logic        dp, frame_done;

  logic        enable1 = 1'b0, load1 = 1'b0, lzb1 = 1'b0;
  logic [15:0] digits1 = '0;
  logic [3:0]  dp_en1 = '0;
  logic [3:0]  dis_sel1;
  logic [6:0]  seg1;
  logic        dp1, frame_done1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg1_tab [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits(digits),
    .dp_en(dp_en), .lzb(lzb), .dis_sel(dis_sel), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .load(load1), .digits(digits1),
    .dp_en(dp_en1), .lzb(lzb1), .dis_sel(dis_sel1), .seg(seg1), .dp(dp1),
    .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, sample 1 time unit later; load strobes are one cycle wide.
  task automatic tick();
    @(posedge clk);
    #1;
    load  = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_sel"}, dis_sel, 4'b1111);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"},  dp, 1'b1);
  endtask

  // Four SHOW cycles of digit d, optional load after the first, then one BLANK cycle.
  task automatic run_digit(input int d, input logic [6:0] s, input logic fd_first,
                           input logic do_ld, input logic [15:0] ld_val);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("d%0d_c%0d_sel", d, c), dis_sel, sel_tab[d]);
      check($sformatf("d%0d_c%0d_seg", d, c), seg, s);
      check($sformatf("d%0d_c%0d_dp", d, c), dp, 1'b1);
      check($sformatf("d%0d_c%0d_fd", d, c), frame_done, (c == 0) ? fd_first : 1'b0);
      if (c == 0 && do_ld) begin
        load   = 1'b1;
        digits = ld_val;
        lzb    = (ld_val == 16'h0050);
      end
    end
    tick();
    check_dark($sformatf("d%0d_blank", d));
    check($sformatf("d%0d_blank_fd", d), frame_done, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check_dark("reset");
    check("reset_fd", frame_done, 1'b0);
    check("reset_nb_sel", dis_sel1, 4'b1111);
    rst_n = 1'b1;
    tick();
    check_dark("idle");

    // Frame 1: 1230 loaded while idle, 8888 loaded mid-frame during digit 1.
    enable = 1'b1;
    load   = 1'b1;
    digits = 16'h1230;
    run_digit(0, 7'b1000000, 1'b0, 1'b0, 16'h0);
    run_digit(1, 7'b0110000, 1'b0, 1'b1, 16'h8888);
    run_digit(2, 7'b0100100, 1'b0, 1'b0, 16'h0);
    run_digit(3, 7'b1111001, 1'b0, 1'b0, 16'h0);

    // Frame 2: all 8s; load 0050 with leading-zero blanking during digit 1.
    run_digit(0, 7'b0000000, 1'b1, 1'b0, 16'h0);
    run_digit(1, 7'b0000000, 1'b0, 1'b1, 16'h0050);
    run_digit(2, 7'b0000000, 1'b0, 1'b0, 16'h0);
    run_digit(3, 7'b0000000, 1'b0, 1'b0, 16'h0);

    // Frame 3: 0050 with lzb -> digits 3,2 blank, digit 1 = 5, digit 0 = 0.
    run_digit(0, 7'b1000000, 1'b1, 1'b0, 16'h0);
    run_digit(1, 7'b0010010, 1'b0, 1'b0, 16'h0);
    run_digit(2, 7'h7F,      1'b0, 1'b0, 16'h0);
    run_digit(3, 7'h7F,      1'b0, 1'b0, 16'h0);

    // Frame 4: drop enable during digit 2 SHOW.
    run_digit(0, 7'b1000000, 1'b1, 1'b0, 16'h0);
    run_digit(1, 7'b0010010, 1'b0, 1'b0, 16'h0);
    tick();
    check("d2_lit_sel", dis_sel, 4'b1011);
    check("d2_lit_seg", seg, 7'h7F);
    enable = 1'b0;
    tick();
    check_dark("disable");
    tick();
    check_dark("disabled");
    enable = 1'b1;
    tick();
    check("reenable_sel", dis_sel, 4'b1110);
    check("reenable_seg", seg, 7'b1000000);
    check("reenable_fd", frame_done, 1'b0);
    tick();
    check("reenable2_sel", dis_sel, 4'b1110);

    // Asynchronous reset mid-SHOW, sampled well before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("async_rst");
    check("async_rst_fd", frame_done, 1'b0);
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check_dark("post_rst_idle");

    // No-blank instance: dp only on digit 2, no dark gap, frame every 16 cycles.
    enable1 = 1'b1;
    load1   = 1'b1;
    digits1 = 16'h4321;
    dp_en1  = 4'b0100;
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          check($sformatf("nb_f%0d_d%0d_c%0d_sel", f, d, c), dis_sel1, sel_tab[d]);
          check($sformatf("nb_f%0d_d%0d_c%0d_seg", f, d, c), seg1, seg1_tab[d]);
          check($sformatf("nb_f%0d_d%0d_c%0d_dp", f, d, c), dp1, (d == 2) ? 1'b0 : 1'b1);
          check($sformatf("nb_f%0d_d%0d_c%0d_fd", f, d, c), frame_done1,
                (f == 1 && d == 0 && c == 0) ? 1'b1 : 1'b0);
        end
      end
    end
    check_dark("main_idle_during_nb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
